// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared types and constants for the data-side SRAM-like to AXI bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_like_axi_bridge_pkg;

    // Bridge FSM: one outstanding transaction, read and write legs kept separate.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_AR = 3'd1,
        RD_R  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        RESP  = 3'd5
    } state_t;

    // SRAM-like transfer sizes (value 3 is folded onto SIZE_WORD).
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // AXI encodings used by the SoC-level tie-offs.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Size 3 has no meaning on a 32-bit bus; treat it as a full word.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SIZE_WORD : size;
    endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-strobe generator: transfer size + low address bits -> 32-bit AXI wstrb.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: size (SRAM-like size code), addr_lo (addr[1:0]), wstrb (4 byte lanes).
module axi_wstrb_gen
    import sram_like_axi_bridge_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            // Halfword lane is chosen by addr[1]; addr[0] is not checked.
            SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// Data-side SRAM-like responder that turns each request into one single-beat AXI read or write.
// Latency: accept at T, AR/AW+W from T+1; data_data_ok one cycle after the R or B handshake.
// Backpressure: data_addr_ok only in IDLE (one outstanding); AXI outputs held stable from latched regs until ready.
// Ports: clk/rst; SRAM-like data_req/data_wr/data_size/data_addr/data_wdata in, data_addr_ok/data_data_ok/data_rdata out;
//        AXI AR/R, AW/W/B channel signals (ids, len, burst, lock, cache, prot are tied off at the SoC top).
module sram_like_axi_bridge
    import sram_like_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    // SRAM-like responder side
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,

    // AXI read address / data
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,

    // AXI write address / data / response
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state;
    state_t              state_nxt;

    logic                aw_done;
    logic                w_done;
    logic                aw_done_nxt;
    logic                w_done_nxt;
    logic                aw_hit;
    logic                w_hit;

    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [STRB_W-1:0]   wstrb_in;

    // Error responses are deliberately not reported back to the core.
    logic                unused_resp;
    assign unused_resp = ^{rresp, bresp};

    // Strobes are computed from the live request and captured with it.
    axi_wstrb_gen u_wstrb_gen (
        .size    (norm_size(data_size)),
        .addr_lo (data_addr[1:0]),
        .wstrb   (wstrb_in)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            // Initiator inputs are don't-care after accept, so everything
            // the AXI side needs is captured here in one go.
            if (data_addr_ok) begin
                size_q  <= norm_size(data_size);
                addr_q  <= data_addr;
                wdata_q <= data_wdata;
                wstrb_q <= wstrb_in;
            end
            if (state == RD_R && rvalid) begin
                rdata_q <= rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        aw_done_nxt  = aw_done;
        w_done_nxt   = w_done;
        aw_hit       = 1'b0;
        w_hit        = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;

        case (state)
            IDLE: begin
                // rst gates the accept so nothing is latched during reset.
                data_addr_ok = data_req & ~rst;
                if (data_addr_ok) begin
                    state_nxt = data_wr ? WR_AW : RD_AR;
                end
            end

            RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nxt = RD_R;
                end
            end

            RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_nxt = RESP;
                end
            end

            WR_AW: begin
                // AW and W run independently; each drops its valid once
                // its own handshake has happened.
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                aw_hit  = aw_done | awready;
                w_hit   = w_done | wready;
                if (aw_hit && w_hit) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = WR_B;
                end else begin
                    aw_done_nxt = aw_hit;
                    w_done_nxt  = w_hit;
                end
            end

            WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_nxt = RESP;
                end
            end

            RESP: begin
                data_data_ok = 1'b1;
                state_nxt    = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // AXI payloads come only from latched registers
    // ------------------------------------------------------------------
    assign araddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awaddr = addr_q;
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    // Read data is presented only alongside the completion pulse.
    assign data_rdata = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
module tb_sram_like_axi_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    sram_like_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model: what transaction is open and which AXI handshakes it has seen.
    logic        m_busy = 1'b0, m_wr = 1'b0;
    logic        m_ar = 1'b0, m_r = 1'b0, m_aw = 1'b0, m_w = 1'b0, m_b = 1'b0;
    logic [1:0]  m_size = 2'd0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    int          m_age = 0, n_done = 0;

    // Handshakes seen in the last observed cycle (feed the random slave/initiator).
    logic hs_acc = 1'b0, hs_ar = 1'b0, hs_r = 1'b0, hs_aw = 1'b0, hs_w = 1'b0, hs_b = 1'b0;

    // Random slave / initiator bookkeeping.
    logic r_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0, stop_new = 1'b0;
    int   r_wait = 0, b_wait = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'd0) return 4'b0001 << lo;
        if (sz == 2'd1) return lo[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe one cycle at the falling edge and check it against the model.
    task automatic look();
        logic [6:0] exp_ctl, act_ctl;
        @(negedge clk);
        {hs_acc, hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
        if (rst) begin
            chk("addr_ok_in_reset", 32'(data_addr_ok), 32'd0);
            m_busy = 1'b0;
            return;
        end
        exp_ctl = { !m_busy && data_req,
                    m_busy && (m_wr ? m_b : m_r),
                    m_busy && !m_wr && !m_ar,
                    m_busy && !m_wr && m_ar && !m_r,
                    m_busy && m_wr && !m_aw,
                    m_busy && m_wr && !m_w,
                    m_busy && m_wr && m_aw && m_w && !m_b };
        act_ctl = {data_addr_ok, data_data_ok, arvalid, rready, awvalid, wvalid, bready};
        chk("ctl{aok,dok,arv,rrdy,awv,wv,brdy}", 32'(act_ctl), 32'(exp_ctl));
        if (exp_ctl[4]) begin
            chk("araddr", araddr, m_addr);
            chk("arsize", 32'(arsize), 32'({1'b0, m_size}));
        end
        if (exp_ctl[2]) begin
            chk("awaddr", awaddr, m_addr);
            chk("awsize", 32'(awsize), 32'({1'b0, m_size}));
        end
        if (exp_ctl[1]) begin
            chk("wdata", wdata, m_wdata);
            chk("wstrb", 32'(wstrb), 32'(strb_of(m_size, m_addr[1:0])));
        end
        if (exp_ctl[5] && !m_wr) chk("data_rdata", data_rdata, m_rdata);

        hs_ar = exp_ctl[4] && arready;
        hs_r  = exp_ctl[3] && rvalid;
        hs_aw = exp_ctl[2] && awready;
        hs_w  = exp_ctl[1] && wready;
        hs_b  = exp_ctl[0] && bvalid;
        if (hs_ar) m_ar = 1'b1;
        if (hs_r) begin m_r = 1'b1; m_rdata = rdata; end
        if (hs_aw) m_aw = 1'b1;
        if (hs_w) m_w = 1'b1;
        if (hs_b) m_b = 1'b1;
        if (exp_ctl[5]) begin m_busy = 1'b0; n_done++; end
        if (exp_ctl[6]) begin
            hs_acc  = 1'b1;
            m_busy  = 1'b1;
            m_wr    = data_wr;
            m_size  = (data_size == 2'd3) ? 2'd2 : data_size;
            m_addr  = data_addr;
            m_wdata = data_wdata;
            {m_ar, m_r, m_aw, m_w, m_b} = '0;
            m_age   = 0;
        end
        if (m_busy) begin
            m_age++;
            if (m_age == 80) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL hang: transaction open %0d cycles, required completion", m_age);
            end
        end
    endtask

    task automatic garble();
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 3));
        data_addr  = $urandom;
        data_wdata = $urandom;
    endtask

    task automatic gen_req();
        garble();
        data_req = 1'b1;
    endtask

    // One random cycle of initiator + AXI slave, reacting to last cycle's handshakes.
    task automatic rand_drive();
        if (hs_acc) begin
            if (!stop_new && $urandom_range(0, 1) == 1) gen_req();
            else begin data_req = 1'b0; garble(); end
        end else if (!data_req) begin
            garble();
            if (!stop_new && $urandom_range(0, 2) == 0) gen_req();
        end
        arready = ($urandom_range(0, 2) != 0);
        awready = ($urandom_range(0, 2) != 0);
        wready  = ($urandom_range(0, 2) != 0);
        if (hs_r) begin rvalid = 1'b0; r_pend = 1'b0; end
        if (hs_ar) begin r_pend = 1'b1; r_wait = $urandom_range(0, 3); end
        if (r_pend && !rvalid) begin
            if (r_wait == 0) begin
                rvalid = 1'b1;
                rdata  = $urandom;
                rresp  = 2'($urandom_range(0, 3));
            end else r_wait--;
        end
        if (hs_aw) begin aw_got = 1'b1; b_wait = $urandom_range(0, 3); end
        if (hs_w) begin w_got = 1'b1; b_wait = $urandom_range(0, 3); end
        if (hs_b) begin bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; end
        if (aw_got && w_got && !bvalid && !hs_b) begin
            if (b_wait == 0) begin
                bvalid = 1'b1;
                bresp  = 2'($urandom_range(0, 3));
            end else b_wait--;
        end
    endtask

    // Directed single read with ar_delay cycles of AR backpressure.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] rd, input int ar_delay);
        tick();
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = addr;
        look();
        chk("rd_accept", 32'(data_addr_ok), 32'd1);
        for (int k = 0; k <= ar_delay; k++) begin
            tick();
            data_req = 1'b0; data_addr = $urandom; data_size = 2'($urandom_range(0, 3));
            arready = (k == ar_delay);
            look();
            chk("rd_arvalid", 32'(arvalid), 32'd1);
            chk("rd_araddr_lit", araddr, addr);
            chk("rd_arsize_lit", 32'(arsize), 32'h2);
        end
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = rd; rresp = 2'b10;
        look();
        chk("rd_rready", 32'(rready), 32'd1);
        tick();
        rvalid = 1'b0; rdata = $urandom;
        look();
        chk("rd_data_ok", 32'(data_data_ok), 32'd1);
        chk("rd_data_lit", data_rdata, rd);
    endtask

    initial begin
        rst = 1'b1;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1234_5678; data_wdata = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        look();
        tick();
        rst = 1'b0; data_req = 1'b0;
        look();
        chk("reset_ctl", 32'({arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}), 32'd0);
        chk("reset_rdata", data_rdata, 32'd0);

        // Read word, AR accepted at once, R one cycle later.
        do_read(32'h8000_0010, 32'hDEAD_BEEF, 0);

        // Byte write at lane 3.
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h1000_0003; data_wdata = 32'hAB00_0000;
        look();
        chk("bw_accept", 32'(data_addr_ok), 32'd1);
        tick();
        data_req = 1'b0; garble(); awready = 1'b1; wready = 1'b1;
        look();
        chk("bw_wstrb_lit", 32'(wstrb), 32'h8);
        chk("bw_wdata_lit", wdata, 32'hAB00_0000);
        chk("bw_awsize_lit", 32'(awsize), 32'h0);
        chk("bw_awaddr_lit", awaddr, 32'h1000_0003);
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b11;
        look();
        chk("bw_bready", 32'(bready), 32'd1);
        tick();
        bvalid = 1'b0;
        look();
        chk("bw_data_ok", 32'(data_data_ok), 32'd1);

        // Half write, W accepted three cycles before AW.
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h2000_0006; data_wdata = 32'h1234_0000;
        look();
        chk("hw_accept", 32'(data_addr_ok), 32'd1);
        tick();
        data_req = 1'b0; garble(); wready = 1'b1; awready = 1'b0;
        look();
        chk("hw_wstrb_lit", 32'(wstrb), 32'hC);
        chk("hw_awvalid", 32'(awvalid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            wready = 1'b0; awready = (k == 2);
            look();
            chk("hw_wvalid_dropped", 32'(wvalid), 32'd0);
            chk("hw_awvalid_held", 32'(awvalid), 32'd1);
            chk("hw_bready_early", 32'(bready), 32'd0);
        end
        tick();
        awready = 1'b0; bvalid = 1'b1;
        look();
        chk("hw_bready", 32'(bready), 32'd1);
        tick();
        bvalid = 1'b0;
        look();
        chk("hw_data_ok", 32'(data_data_ok), 32'd1);

        // AR backpressure for 5 cycles with the initiator address wandering.
        do_read(32'h8000_1234, 32'h0F0F_A5A5, 5);

        // Back-to-back reads with data_req held.
        tick();
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h4000_0100;
        look();
        chk("b2b_acc_a", 32'(data_addr_ok), 32'd1);
        tick();
        data_addr = 32'h4000_0200; data_size = 2'd1; arready = 1'b1;
        look();
        chk("b2b_araddr_a", araddr, 32'h4000_0100);
        chk("b2b_hold_1", 32'(data_addr_ok), 32'd0);
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_2222;
        look();
        chk("b2b_hold_2", 32'(data_addr_ok), 32'd0);
        tick();
        rvalid = 1'b0;
        look();
        chk("b2b_dok_a", 32'(data_data_ok), 32'd1);
        chk("b2b_hold_3", 32'(data_addr_ok), 32'd0);
        tick();
        look();
        chk("b2b_acc_b", 32'(data_addr_ok), 32'd1);
        tick();
        data_req = 1'b0; arready = 1'b1;
        look();
        chk("b2b_araddr_b", araddr, 32'h4000_0200);
        chk("b2b_arsize_b", 32'(arsize), 32'h1);
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h3333_4444;
        look();
        tick();
        rvalid = 1'b0;
        look();
        chk("b2b_dok_b", 32'(data_data_ok), 32'd1);
        chk("b2b_rdata_b", data_rdata, 32'h3333_4444);

        // Reset while waiting for B; size 3 must behave as a word.
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd3; data_addr = 32'h3000_0000; data_wdata = 32'hCAFE_F00D;
        look();
        tick();
        data_req = 1'b0; awready = 1'b1; wready = 1'b1;
        look();
        chk("rw_awsize_lit", 32'(awsize), 32'h2);
        chk("rw_wstrb_lit", 32'(wstrb), 32'hF);
        tick();
        awready = 1'b0; wready = 1'b0;
        look();
        chk("rw_in_wr_b", 32'(bready), 32'd1);
        tick();
        rst = 1'b1;
        look();
        tick();
        rst = 1'b0;
        look();
        chk("post_reset_ctl", 32'({arvalid, rready, awvalid, wvalid, bready, data_data_ok}), 32'd0);
        do_read(32'h5000_0004, 32'h0BAD_F00D, 1);

        // Randomized traffic against the model.
        {arready, awready, wready, rvalid, bvalid} = '0;
        data_req = 1'b0;
        {hs_acc, hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
        n_done = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            rand_drive();
            look();
        end
        stop_new = 1'b1;
        for (int c = 0; c < 150; c++) begin
            tick();
            rand_drive();
            look();
        end
        chk("drain_ctl", 32'({arvalid, rready, awvalid, wvalid, bready, data_data_ok}), 32'd0);
        chk("random_traffic_flowed", 32'(n_done > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
